// File: rtl/lk_pkg.sv
// Shared definitions for the linked-list summation controller and datapath.
package lk_pkg;

  // ROM index width and the pointer value that terminates a list
  localparam int ADDR_W = 4;
  localparam logic [ADDR_W-1:0] NULL_PTR = '0;

  // Controller states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    ADD  = 3'd2,
    LINK = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } lk_state_e;

  // Bit positions inside the datapath strobe bundle
  localparam int STB_SUM_SEL   = 0;
  localparam int STB_SUM_LOAD  = 1;
  localparam int STB_NEXT_SEL  = 2;
  localparam int STB_NEXT_LOAD = 3;
  localparam int STB_MEM_SEL   = 4;
  localparam int STB_W         = 5;

  // Strobe pattern for each state; select bits whose load is off are left at 0
  function automatic logic [STB_W-1:0] strobes_for(input lk_state_e s);
    logic [STB_W-1:0] v;
    v = '0;
    case (s)
      INIT: begin
        v[STB_SUM_LOAD]  = 1'b1;
        v[STB_NEXT_LOAD] = 1'b1;
      end
      ADD: begin
        v[STB_SUM_SEL]  = 1'b1;
        v[STB_SUM_LOAD] = 1'b1;
      end
      LINK: begin
        v[STB_MEM_SEL]   = 1'b1;
        v[STB_NEXT_SEL]  = 1'b1;
        v[STB_NEXT_LOAD] = 1'b1;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/lksum_controller.sv
// Moore controller sequencing the linked-list summation datapath:
// clear, then ADD/LINK per node until the fetched link is null,
// with a node counter that aborts cyclic or overlong lists.
module lksum_controller
  import lk_pkg::*;
#(
  parameter int MAX_NODES = 8,
  parameter int CNT_W     = 4
) (
  input  logic             all_clk,
  input  logic             all_reset,
  input  logic             start,
  input  logic             next_zero,
  output logic             sum_sel,
  output logic             sum_load,
  output logic             next_sel,
  output logic             next_load,
  output logic             mem_sel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] node_count
);

  lk_state_e        state_q;
  lk_state_e        state_d;
  logic [STB_W-1:0] stb;
  logic             at_limit;

  assign at_limit = (node_count == CNT_W'(MAX_NODES));

  // State register; reset returns to IDLE from anywhere, including mid-run
  always_ff @(posedge all_clk) begin
    if (all_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Node counter: cleared when a run is accepted, bumped once per ADD, saturating at the limit
  always_ff @(posedge all_clk) begin
    if (all_reset) begin
      node_count <= '0;
    end else if (state_q == IDLE && start) begin
      node_count <= '0;
    end else if (state_q == ADD && !at_limit) begin
      node_count <= node_count + CNT_W'(1);
    end
  end

  // Next-state and state-decoded outputs; a null link wins over the limit so a list ending exactly at the limit succeeds
  always_comb begin
    state_d = state_q;
    stb     = strobes_for(state_q);
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = INIT;
      end
      INIT: begin
        busy    = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        busy    = 1'b1;
        state_d = LINK;
      end
      LINK: begin
        busy = 1'b1;
        if (next_zero) begin
          state_d = DONE;
        end else if (at_limit) begin
          state_d = ERR;
        end else begin
          state_d = ADD;
        end
      end
      DONE: begin
        done = 1'b1;
        if (!start) state_d = IDLE;
      end
      ERR: begin
        done = 1'b1;
        err  = 1'b1;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sum_sel   = stb[STB_SUM_SEL];
  assign sum_load  = stb[STB_SUM_LOAD];
  assign next_sel  = stb[STB_NEXT_SEL];
  assign next_load = stb[STB_NEXT_LOAD];
  assign mem_sel   = stb[STB_MEM_SEL];

endmodule
